imm_ext_pipe: RTL and testbench

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

---
 rtl/imm_pkg.sv | 17 +
 rtl/imm_ext_pipe_if.sv | 28 ++
 rtl/imm_ext_core.sv | 36 +++
 rtl/imm_ext_pipe.sv | 106 ++++++++++
 tb/tb_imm_ext_pipe.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
// Shared encodings for the immediate extension pipe: extension modes and skid-buffer states.
package imm_pkg;

    typedef enum logic [1:0] {
        MODE_SIGN   = 2'b00,
        MODE_ZERO   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle for imm_ext_pipe: input offer, output result, flush and delivery count.
interface imm_ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_imm;
    logic [1:0]        in_mode;
    logic [TAG_W-1:0]  in_tag;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_imm;
    logic [TAG_W-1:0]  out_tag;
    logic [15:0]       out_count;

    modport master (
        output in_valid, in_imm, in_mode, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_count
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, flush, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_count
    );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: SIGN, ZERO, UPPER or BRANCH (sign-extended, <<2).
// Zero latency, no state, no backpressure.
module imm_ext_core
    import imm_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  mode_e            mode,
    output logic [OUT_W-1:0] ext
);
    if (IN_W < 2 || IN_W >= OUT_W) begin : g_bad_width
        $error("imm_ext_core: IN_W must lie in 2..OUT_W-1");
    end

    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] upper_ext;

    assign sign_ext  = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    assign zero_ext  = {{(OUT_W-IN_W){1'b0}}, imm};
    assign upper_ext = {imm, {(OUT_W-IN_W){1'b0}}};

    always_comb begin
        ext = sign_ext;
        case (mode)
            MODE_SIGN:   ext = sign_ext;
            MODE_ZERO:   ext = zero_ext;
            MODE_UPPER:  ext = upper_ext;
            // top two bits of the sign result fall off silently
            MODE_BRANCH: ext = {sign_ext[OUT_W-3:0], 2'b00};
            default:     ext = sign_ext;
        endcase
    end
endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate extension stage feeding a 2-entry skid FIFO of finished results plus tag.
// Latency 1 cycle when empty; in_ready registered, low only when both entries are held.
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic         clk,
    input  logic         reset,
    imm_ext_pipe_if.slave bus
);
    typedef struct packed {
        logic [OUT_W-1:0] imm;
        logic [TAG_W-1:0] tag;
    } entry_t;

    state_e           state_q;
    state_e           state_d;
    entry_t           head_q;
    entry_t           skid_q;
    entry_t           in_ent;
    logic             in_ready_q;
    logic             out_valid;
    logic             in_xfer;
    logic             out_xfer;
    logic             load_head;
    logic             load_skid;
    logic [15:0]      count_q;
    logic [OUT_W-1:0] ext;

    imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
        .imm  (bus.in_imm),
        .mode (mode_e'(bus.in_mode)),
        .ext  (ext)
    );

    assign in_ent.imm = ext;
    assign in_ent.tag = bus.in_tag;

    // in_ready follows the next state so it never sees out_ready combinationally
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_xfer) state_d = ST_ONE;
                ST_ONE: begin
                    if (in_xfer && !out_xfer)      state_d = ST_FULL;
                    else if (!in_xfer && out_xfer) state_d = ST_EMPTY;
                end
                ST_FULL:  if (out_xfer) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        in_xfer   = bus.in_valid && in_ready_q;
        out_xfer  = out_valid && bus.out_ready;
        load_head = 1'b0;
        load_skid = 1'b0;
        if (!bus.flush) begin
            case (state_q)
                ST_EMPTY: load_head = in_xfer;
                ST_ONE: begin
                    load_head = in_xfer && out_xfer;
                    load_skid = in_xfer && !out_xfer;
                end
                ST_FULL:  load_head = out_xfer;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            skid_q  <= '0;
            count_q <= '0;
        end else begin
            if (load_head) head_q <= (state_q == ST_FULL) ? skid_q : in_ent;
            if (load_skid) skid_q <= in_ent;
            if (out_xfer && !bus.flush) count_q <= count_q + 16'd1;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_imm   = head_q.imm;
    assign bus.out_tag   = head_q.tag;
    assign bus.out_count = count_q;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: modes, backpressure, flush, streaming, reset, narrow input and count wrap.
module tb_imm_ext_pipe;
    import imm_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    imm_ext_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus ();
    imm_ext_pipe_if #(.IN_W(12), .OUT_W(32), .TAG_W(5)) bus12 ();

    imm_ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk (clk), .reset (reset), .bus (bus)
    );
    imm_ext_pipe #(.IN_W(12), .OUT_W(32), .TAG_W(5)) dut12 (
        .clk (clk), .reset (reset), .bus (bus12)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0; bus.in_imm = '0; bus.in_mode = 2'b00; bus.in_tag = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        bus12.in_valid = 1'b0; bus12.in_imm = '0; bus12.in_mode = 2'b00; bus12.in_tag = '0;
        bus12.flush = 1'b0; bus12.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic offer(input logic [15:0] imm, input mode_e mode, input logic [4:0] tag);
        bus.in_valid = 1'b1; bus.in_imm = imm; bus.in_mode = mode; bus.in_tag = tag;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        tests_run++; if (bus.out_imm !== 32'h0) begin tests_failed++; $display("FAIL reset_out_imm: got %h want 0", bus.out_imm); end
        tests_run++; if (bus.out_tag !== 5'h0) begin tests_failed++; $display("FAIL reset_out_tag: got %h want 0", bus.out_tag); end
        tests_run++; if (bus.out_count !== 16'h0) begin tests_failed++; $display("FAIL reset_out_count: got %h want 0", bus.out_count); end
    endtask

    task automatic test_modes();
        logic [31:0] exp_imm [4];
        mode_e       modes [4];
        exp_imm[0] = 32'hFFFF8004; modes[0] = MODE_SIGN;
        exp_imm[1] = 32'h00008004; modes[1] = MODE_ZERO;
        exp_imm[2] = 32'h80040000; modes[2] = MODE_UPPER;
        exp_imm[3] = 32'hFFFE0010; modes[3] = MODE_BRANCH;
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(16'h8004, modes[i], 5'(i + 7));
            tick();
            tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL modes_valid[%0d]: got %b want 1", i, bus.out_valid); end
            tests_run++; if (bus.out_imm !== exp_imm[i]) begin tests_failed++; $display("FAIL modes_imm[%0d]: got %h want %h", i, bus.out_imm, exp_imm[i]); end
            tests_run++; if (bus.out_tag !== 5'(i + 7)) begin tests_failed++; $display("FAIL modes_tag[%0d]: got %h want %h", i, bus.out_tag, 5'(i + 7)); end
        end
        bus.in_valid = 1'b0;
        tick();
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL modes_drain_valid: got %b want 0", bus.out_valid); end
        tests_run++; if (bus.out_count !== 16'd4) begin tests_failed++; $display("FAIL modes_count: got %0d want 4", bus.out_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        offer(16'h0011, MODE_ZERO, 5'd1);
        tick();
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_one: got %b want 1", bus.in_ready); end
        offer(16'h0022, MODE_ZERO, 5'd2);
        tick();
        tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_full: got %b want 0", bus.in_ready); end
        offer(16'h0033, MODE_ZERO, 5'd3);
        tick();
        tick();
        tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_held: got %b want 0", bus.in_ready); end
        tests_run++; if (bus.out_imm !== 32'h11 || bus.out_tag !== 5'd1) begin tests_failed++; $display("FAIL bp_stable: got %h/%0d want 00000011/1", bus.out_imm, bus.out_tag); end
        bus.out_ready = 1'b1;
        tick();
        tests_run++; if (bus.out_imm !== 32'h22 || bus.out_tag !== 5'd2) begin tests_failed++; $display("FAIL bp_second: got %h/%0d want 00000022/2", bus.out_imm, bus.out_tag); end
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_reopen: got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        tests_run++; if (bus.out_imm !== 32'h33 || bus.out_tag !== 5'd3) begin tests_failed++; $display("FAIL bp_third: got %h/%0d want 00000033/3", bus.out_imm, bus.out_tag); end
        tick();
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drained: got %b want 0", bus.out_valid); end
        tests_run++; if (bus.out_count !== 16'd3) begin tests_failed++; $display("FAIL bp_count: got %0d want 3", bus.out_count); end
    endtask

    task automatic test_flush();
        do_reset();
        bus.out_ready = 1'b0;
        offer(16'h0AAA, MODE_ZERO, 5'd4);
        tick();
        offer(16'h0BBB, MODE_ZERO, 5'd5);
        tick();
        offer(16'h0001, MODE_ZERO, 5'd6);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_ready: got %b want 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_no_ghost[%0d]: got %b want 0", i, bus.out_valid); end
        end
        offer(16'h0005, MODE_ZERO, 5'd7);
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_one_valid: got %b want 0", bus.out_valid); end
        tests_run++; if (bus.out_count !== 16'd0) begin tests_failed++; $display("FAIL flush_count: got %0d want 0", bus.out_count); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        do_reset();
        bus.out_ready = 1'b1;
        offer(16'h0000, MODE_ZERO, 5'd0);
        tick();
        for (int k = 1; k <= 10; k++) begin
            v = 16'(k * 16'h0101);
            offer(v, MODE_ZERO, 5'(k));
            tick();
            tests_run++; if (bus.out_imm !== {16'h0, v} || bus.out_tag !== 5'(k)) begin tests_failed++; $display("FAIL b2b_data[%0d]: got %h/%0d want %h/%0d", k, bus.out_imm, bus.out_tag, {16'h0, v}, k); end
            tests_run++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_state[%0d]: got valid %b ready %b want 1 1", k, bus.out_valid, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        tests_run++; if (bus.out_count !== 16'd10) begin tests_failed++; $display("FAIL b2b_count: got %0d want 10", bus.out_count); end
        tick();
    endtask

    task automatic test_reset_full();
        do_reset();
        bus.out_ready = 1'b1;
        offer(16'h0123, MODE_ZERO, 5'd1);
        tick();
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        offer(16'h8004, MODE_SIGN, 5'd2);
        tick();
        offer(16'h8004, MODE_BRANCH, 5'd3);
        tick();
        tests_run++; if (bus.in_ready !== 1'b0 || bus.out_count !== 16'd1) begin tests_failed++; $display("FAIL rstfull_pre: got ready %b count %0d want 0 1", bus.in_ready, bus.out_count); end
        reset = 1'b1;
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        reset = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstfull_valid: got %b want 0", bus.out_valid); end
        tests_run++; if (bus.out_imm !== 32'h0) begin tests_failed++; $display("FAIL rstfull_imm: got %h want 0", bus.out_imm); end
        tests_run++; if (bus.out_count !== 16'h0) begin tests_failed++; $display("FAIL rstfull_count: got %0d want 0", bus.out_count); end
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL rstfull_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_narrow_wrap();
        logic [31:0] exp_imm [4];
        mode_e       modes [4];
        exp_imm[0] = 32'hFFFFF800; modes[0] = MODE_SIGN;
        exp_imm[1] = 32'h80000000; modes[1] = MODE_UPPER;
        exp_imm[2] = 32'hFFFFE000; modes[2] = MODE_BRANCH;
        exp_imm[3] = 32'h00000800; modes[3] = MODE_ZERO;
        do_reset();
        bus12.out_ready = 1'b1;
        bus12.in_valid = 1'b1;
        bus12.in_imm = 12'h800;
        bus12.in_tag = 5'd3;
        for (int i = 0; i < 4; i++) begin
            bus12.in_mode = modes[i];
            tick();
            tests_run++; if (bus12.out_imm !== exp_imm[i] || bus12.out_tag !== 5'd3) begin tests_failed++; $display("FAIL narrow_imm[%0d]: got %h/%0d want %h/3", i, bus12.out_imm, bus12.out_tag, exp_imm[i]); end
            tests_run++; if (bus12.out_count !== 16'(i)) begin tests_failed++; $display("FAIL narrow_count[%0d]: got %0d want %0d", i, bus12.out_count, i); end
        end
        for (int i = 0; i < 65532; i++) tick();
        tests_run++; if (bus12.out_count !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_preset: got %h want ffff", bus12.out_count); end
        tick();
        tests_run++; if (bus12.out_count !== 16'h0000) begin tests_failed++; $display("FAIL wrap_zero: got %h want 0000", bus12.out_count); end
        bus12.in_valid = 1'b0;
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_modes();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_full();
        test_narrow_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
